// File: rtl/dmem_bus_bridge_if.sv
// Multi-cycle data bus between the DMEM bridge (master) and the memory/fabric (slave).
// Request uses a valid/ready handshake; read data returns separately, qualified by bus_rvalid.
interface dmem_bus_bridge_if;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata,
    input  bus_ready, bus_rdata, bus_rvalid
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata,
    output bus_ready, bus_rdata, bus_rvalid
  );
endinterface

// File: rtl/dmem_bus_bridge.sv
// Turns the single-cycle CPU data-memory port into one bus transaction per access.
// The core is held off via cpu_ena_o until the access has completed, failed the range check or timed out.
module dmem_bus_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 2048,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_ena_i,
  input  logic                  dm_ena_i,
  input  logic                  dm_r_i,
  input  logic                  dm_w_i,
  input  logic [31:0]           dm_addr_i,
  input  logic [31:0]           dm_data_w_i,
  output logic [31:0]           dm_data_o,
  output logic                  cpu_ena_o,
  dmem_bus_bridge_if.master     bus,
  output logic                  err_range_o,
  output logic                  err_timeout_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  localparam logic [31:0] SPAN    = 32'(4 * DEPTH_WORDS);
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        valid_q, valid_d;
  logic        we_q, we_d;
  logic        err_range_q, err_range_d;
  logic        err_timeout_q, err_timeout_d;

  logic [31:0] offset;
  logic        addr_ok;
  logic        accept;
  logic        unused_ok;

  // Addresses below BASE_ADDR wrap to huge offsets, so one unsigned compare covers both ends.
  assign offset    = dm_addr_i - BASE_ADDR;
  assign addr_ok   = (offset < SPAN) && (dm_addr_i[1:0] == 2'b00);
  assign accept    = valid_q && bus.bus_ready;
  assign unused_ok = ^{dm_r_i, offset[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      rdata_q       <= 32'h0;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      valid_q       <= 1'b0;
      we_q          <= 1'b0;
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      valid_q       <= valid_d;
      we_q          <= we_d;
      err_range_q   <= err_range_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    valid_d       = valid_q;
    we_d          = we_q;
    err_range_d   = err_range_q;
    err_timeout_d = err_timeout_q;

    case (state_q)
      IDLE: begin
        if (dm_ena_i) begin
          if (!addr_ok) begin
            err_range_d = 1'b1;
            rdata_d     = ERR_DATA;
            state_d     = DONE;
          end else begin
            valid_d = 1'b1;
            we_d    = dm_w_i;
            addr_d  = {2'b00, offset[31:2]};
            wdata_d = dm_data_w_i;
            cnt_d   = 8'd0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (accept) begin
          valid_d = 1'b0;
          if (we_q) begin
            state_d = DONE;
          end else if (bus.bus_rvalid) begin
            rdata_d = bus.bus_rdata;
            state_d = DONE;
          end else begin
            state_d = RESP;
          end
        end else if (cnt_q == TO_LAST) begin
          valid_d       = 1'b0;
          err_timeout_d = 1'b1;
          rdata_d       = ERR_DATA;
          state_d       = DONE;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 8'd1;
        // A response landing on the last allowed cycle still counts as completion.
        if (bus.bus_rvalid) begin
          rdata_d = bus.bus_rdata;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          err_timeout_d = 1'b1;
          rdata_d       = ERR_DATA;
          state_d       = DONE;
        end
      end
      DONE: begin
        if (run_ena_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Combinational stall: the cycle in which dm_ena first rises is already held off.
  assign cpu_ena_o     = run_ena_i && !(dm_ena_i && (state_q != DONE));
  assign dm_data_o     = (state_q == DONE) ? rdata_q : 32'h0;
  assign err_range_o   = err_range_q;
  assign err_timeout_o = err_timeout_q;

  assign bus.bus_valid = valid_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Self-checking bench for dmem_bus_bridge: a vector table drives CPU accesses and a bus responder,
// while a negedge monitor pops expected bus requests and CPU completions from scoreboard queues.
module tb_dmem_bus_bridge;

  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic        bothRW;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          readyWait;
    int          rvalidWait;
    logic        expBus;
    logic [31:0] expBusAddr;
    logic [31:0] expData;
    logic        chkData;
    int          expStall;
    logic        expErrRange;
    logic        expErrTimeout;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        chkData;
    int          stall;
    logic        errRange;
    logic        errTimeout;
  } cpuExp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } busExp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        runEna;
  logic        dmEna;
  logic        dmR;
  logic        dmW;
  logic [31:0] dmAddr;
  logic [31:0] dmDataW;
  logic [31:0] dmData;
  logic        cpuEna;
  logic        errRange;
  logic        errTimeout;

  dmem_bus_bridge_if busIf ();

  dmem_bus_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_ena_i    (runEna),
    .dm_ena_i     (dmEna),
    .dm_r_i       (dmR),
    .dm_w_i       (dmW),
    .dm_addr_i    (dmAddr),
    .dm_data_w_i  (dmDataW),
    .dm_data_o    (dmData),
    .cpu_ena_o    (cpuEna),
    .bus          (busIf),
    .err_range_o  (errRange),
    .err_timeout_o(errTimeout)
  );

  always #5 clk = ~clk;

  int      total = 0;
  int      bad   = 0;
  int      stallCnt = 0;
  cpuExp_t cpuQ[$];
  busExp_t busQ[$];
  vec_t    vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: bus requests are checked every valid cycle, CPU completions on commit.
  always @(negedge clk) begin
    if (!rst_n) begin
      stallCnt = 0;
    end else begin
      if (busIf.bus_valid) begin
        if (busQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedValid: got bus_valid=1 expected no request at %0t", $time);
        end else begin
          checkOutput("busAddr", busIf.bus_addr, busQ[0].addr);
          checkOutput("busWe", 32'(busIf.bus_we), 32'(busQ[0].we));
          if (busQ[0].we) checkOutput("busWdata", busIf.bus_wdata, busQ[0].wdata);
          if (busIf.bus_ready) void'(busQ.pop_front());
        end
      end
      if (dmEna && runEna && !cpuEna) stallCnt++;
      if (dmEna && cpuEna) begin
        if (cpuQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedCommit: got commit expected none at %0t", $time);
        end else begin
          cpuExp_t e;
          e = cpuQ.pop_front();
          if (e.chkData) checkOutput("dmData", dmData, e.data);
          checkOutput("stallCycles", 32'(stallCnt), 32'(e.stall));
          checkOutput("errRange", 32'(errRange), 32'(e.errRange));
          checkOutput("errTimeout", 32'(errTimeout), 32'(e.errTimeout));
        end
        stallCnt = 0;
      end
    end
  end

  // Drives one CPU access and plays the bus slave with the vector's ready/response delays.
  task automatic applyStimulus(input vec_t v);
    cpuExp_t ce;
    busExp_t be;
    int      validCnt = 0;
    int      sinceAcc = 0;
    bit      accepted = 0;
    bit      finished = 0;
    bit      accNow;
    bit      vNow;
    bit      doneNow;
    logic    rv;
    if (v.expBus) begin
      be.addr  = v.expBusAddr;
      be.we    = v.we;
      be.wdata = v.wdata;
      busQ.push_back(be);
    end
    ce.data       = v.expData;
    ce.chkData    = v.chkData;
    ce.stall      = v.expStall;
    ce.errRange   = v.expErrRange;
    ce.errTimeout = v.expErrTimeout;
    cpuQ.push_back(ce);
    @(posedge clk);
    #1;
    dmEna   = 1'b1;
    dmR     = !v.we || v.bothRW;
    dmW     = v.we;
    dmAddr  = v.addr;
    dmDataW = v.wdata;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      busIf.bus_ready = busIf.bus_valid && (validCnt >= v.readyWait);
      rv = 1'b0;
      if (!v.we && v.rvalidWait >= 0) begin
        if (!accepted && busIf.bus_ready && v.rvalidWait == 0) rv = 1'b1;
        else if (accepted && sinceAcc == v.rvalidWait) rv = 1'b1;
      end
      busIf.bus_rvalid = rv;
      busIf.bus_rdata  = rv ? v.rdata : 32'hBAD0_0BAD;
      @(negedge clk);
      accNow  = busIf.bus_valid && busIf.bus_ready;
      vNow    = busIf.bus_valid;
      doneNow = dmEna && cpuEna;
      @(posedge clk);
      #1;
      if (accepted) sinceAcc++;
      if (accNow) begin
        accepted = 1;
        sinceAcc = 1;
      end
      if (vNow) validCnt++;
      if (doneNow) finished = 1;
    end
    dmEna            = 1'b0;
    dmR              = 1'b0;
    dmW              = 1'b0;
    busIf.bus_ready  = 1'b0;
    busIf.bus_rvalid = 1'b0;
    if (!finished) begin
      total++;
      bad++;
      $display("[TB] FAIL accessBudget: got no commit within 400 cycles expected commit for addr %h", v.addr);
      void'(cpuQ.pop_back());
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cpuExp_t ce;
    busExp_t be;
    vec_t    pr;

    //               addr           we bRW wdata          rdata          rdy rv   bus busAddr   data           chk stall eR eT
    vecs[0]  = '{32'h1001_0008, 0, 0, 32'h0,          32'h1234_5678, 0, 0,   1, 32'h2,   32'h1234_5678, 1, 2,   0, 0};
    vecs[1]  = '{32'h1001_0010, 1, 0, 32'hCAFE_F00D,  32'h0,         3, -1,  1, 32'h4,   32'h0,         0, 5,   0, 0};
    vecs[2]  = '{32'h1001_1FFC, 0, 0, 32'h0,          32'hA5A5_0001, 1, 2,   1, 32'h7FF, 32'hA5A5_0001, 1, 5,   0, 0};
    vecs[3]  = '{32'h1001_0000, 1, 1, 32'h0BAD_F00D,  32'h0,         0, -1,  1, 32'h0,   32'h0,         0, 2,   0, 0};
    vecs[4]  = '{32'h1001_0004, 0, 0, 32'h0,          32'h0000_00FF, 2, 0,   1, 32'h1,   32'h0000_00FF, 1, 4,   0, 0};
    vecs[5]  = '{32'h1001_2000, 0, 0, 32'h0,          32'h0,         0, 0,   0, 32'h0,   ERR,           1, 1,   1, 0};
    vecs[6]  = '{32'h0000_0004, 0, 0, 32'h0,          32'h0,         0, 0,   0, 32'h0,   ERR,           1, 1,   1, 0};
    vecs[7]  = '{32'h1001_0002, 1, 0, 32'h1111_2222,  32'h0,         0, -1,  0, 32'h0,   ERR,           1, 1,   1, 0};
    vecs[8]  = '{32'h0FFF_FFFC, 0, 0, 32'h0,          32'h0,         0, 0,   0, 32'h0,   ERR,           1, 1,   1, 0};
    vecs[9]  = '{32'h1001_0020, 0, 0, 32'h0,          32'h7777_0001, 0, 254, 1, 32'h8,   32'h7777_0001, 1, 256, 1, 0};
    vecs[10] = '{32'h1001_0024, 0, 0, 32'h0,          32'h0,         0, -1,  1, 32'h9,   ERR,           1, 256, 1, 1};
    vecs[11] = '{32'h1001_0028, 0, 0, 32'h0,          32'h1357_9BDF, 0, 1,   1, 32'hA,   32'h1357_9BDF, 1, 3,   1, 1};

    rst_n            = 1'b0;
    runEna           = 1'b1;
    dmEna            = 1'b0;
    dmR              = 1'b0;
    dmW              = 1'b0;
    dmAddr           = 32'h0;
    dmDataW          = 32'h0;
    busIf.bus_ready  = 1'b0;
    busIf.bus_rvalid = 1'b0;
    busIf.bus_rdata  = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstValid", 32'(busIf.bus_valid), 32'd0);
    checkOutput("rstWe", 32'(busIf.bus_we), 32'd0);
    checkOutput("rstAddr", busIf.bus_addr, 32'h0);
    checkOutput("rstWdata", busIf.bus_wdata, 32'h0);
    checkOutput("rstErrRange", 32'(errRange), 32'd0);
    checkOutput("rstErrTimeout", 32'(errTimeout), 32'd0);
    checkOutput("rstDmData", dmData, 32'h0);
    checkOutput("rstCpuEna", 32'(cpuEna), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Stray responses while idle after the timeout must not disturb anything.
    busIf.bus_rvalid = 1'b1;
    busIf.bus_rdata  = 32'h5A5A_5A5A;
    repeat (2) begin
      @(negedge clk);
      checkOutput("idleRvalidData", dmData, 32'h0);
      checkOutput("idleRvalidCpuEna", 32'(cpuEna), 32'd1);
      checkOutput("idleRvalidValid", 32'(busIf.bus_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    busIf.bus_rvalid = 1'b0;

    // run_ena low: completion must hold in DONE with stable data, ignoring responses before acceptance and after.
    be.addr = 32'h10; be.we = 1'b0; be.wdata = 32'h0;
    busQ.push_back(be);
    ce.data = 32'h2468_ACE0; ce.chkData = 1'b1; ce.stall = 0; ce.errRange = 1'b1; ce.errTimeout = 1'b1;
    cpuQ.push_back(ce);
    runEna           = 1'b0;
    dmEna            = 1'b1;
    dmR              = 1'b1;
    dmW              = 1'b0;
    dmAddr           = 32'h1001_0040;
    busIf.bus_rvalid = 1'b1;
    busIf.bus_rdata  = 32'h1111_1111;
    @(posedge clk);
    #1;
    busIf.bus_rdata = 32'h2222_2222;
    @(negedge clk);
    checkOutput("reqValid", 32'(busIf.bus_valid), 32'd1);
    @(posedge clk);
    #1;
    busIf.bus_ready = 1'b1;
    busIf.bus_rdata = 32'h2468_ACE0;
    @(posedge clk);
    #1;
    busIf.bus_ready = 1'b0;
    busIf.bus_rdata = 32'h3333_3333;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("holdData", dmData, 32'h2468_ACE0);
      checkOutput("holdCpuEna", 32'(cpuEna), 32'd0);
      @(posedge clk);
      #1;
      busIf.bus_rvalid = 1'b0;
    end
    runEna = 1'b1;
    @(posedge clk);
    #1;
    dmEna = 1'b0;
    dmR   = 1'b0;
    @(negedge clk);
    checkOutput("afterCommitData", dmData, 32'h0);

    // Reset while waiting in RESP aborts the access and clears the sticky errors.
    be.addr = 32'hC; be.we = 1'b0; be.wdata = 32'h0;
    busQ.push_back(be);
    @(posedge clk);
    #1;
    dmEna  = 1'b1;
    dmR    = 1'b1;
    dmAddr = 32'h1001_0030;
    @(posedge clk);
    #1;
    busIf.bus_ready = 1'b1;
    @(posedge clk);
    #1;
    busIf.bus_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abortValid", 32'(busIf.bus_valid), 32'd0);
    checkOutput("abortErrRange", 32'(errRange), 32'd0);
    checkOutput("abortErrTimeout", 32'(errTimeout), 32'd0);
    checkOutput("abortDmData", dmData, 32'h0);
    checkOutput("abortCpuEna", 32'(cpuEna), 32'd0);
    dmEna            = 1'b0;
    dmR              = 1'b0;
    busIf.bus_rvalid = 1'b1;
    busIf.bus_rdata  = 32'h9999_9999;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("lateRvalidData", dmData, 32'h0);
    checkOutput("lateRvalidCpuEna", 32'(cpuEna), 32'd1);
    @(posedge clk);
    #1;
    busIf.bus_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("lateRvalidValid", 32'(busIf.bus_valid), 32'd0);

    pr = '{32'h1001_0034, 0, 0, 32'h0, 32'h0F0F_F0F0, 1, 1, 1, 32'hD, 32'h0F0F_F0F0, 1, 4, 0, 0};
    applyStimulus(pr);

    repeat (2) @(posedge clk);
    checkOutput("cpuQDrained", 32'(cpuQ.size()), 32'd0);
    checkOutput("busQDrained", 32'(busQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
